hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Next-generation hazard unit for the 5-stage pipeline (F/D/E/M/W). Adds these to
//  MEM->E / WB->E forwarding: load-use stall, branch flush, and a multi-cycle
//  MUL/DIV hold FSM that freezes F/D/E for MDU_LAT cycles. Also adds a saturating
//  stall-cycle counter and a forwarding-disable mode.
// PARAMETERS
//  REG_AW   5  register-address width
//  MDU_LAT  4  total E-stage occupancy of a MUL/DIV op, in cycles (>=1; 1 = no hold)
//  FWD_EN   1  1: forward from M/W; 0: no forwarding, interlock on RAW instead
//  CNT_W    16 width of the stall performance counter
// PORTS
//  clk        in   1       pipeline clock
//  rst        in   1       synchronous, active-high reset
//  Rs1D,Rs2D  in   REG_AW  D-stage source registers
//  Rs1E,Rs2E  in   REG_AW  E-stage source registers
//  RdE,RdM,RdW in  REG_AW  destination registers in E/M/W
//  RegWriteE/M/W in 1      stage writes the register file
//  ResultSrcE0 in  1       E-stage instruction is a load
//  PCSrcE     in   1       branch/jump taken in E
//  MulDivE    in   1       E-stage instruction is MUL/DIV
//  StallF,StallD,StallE out 1  hold the F, D and E pipeline registers
//  FlushD,FlushE,FlushM out 1  bubble into the D, E and M pipeline registers
//  ForwardAE,ForwardBE out 2   00 regfile, 10 ALUResultM, 01 ResultW
//  MdDoneE    out  1       final cycle of a MUL/DIV op; result is valid in E
//  StallCnt   out  CNT_W   count of cycles with StallF=1 (saturating)
// BEHAVIOUR
//  - Reset: while rst=1, all outputs are 0 and mdu_cnt and StallCnt are cleared.
//  - Forwarding (combinational, FWD_EN=1): for A (B likewise with Rs2E):
//    - 10 when RegWriteM & RdM!=0 & RdM==Rs1E.
//    - Else 01 when RegWriteW & RdW!=0 & RdW==Rs1E.
//    - Else 00. M beats W on a double match. FWD_EN=0 forces 00.
//  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
//  - rawStall (FWD_EN=0 only): RegWriteE/M with Rd!=0 matching Rs1D/Rs2D.
//    W needs no stall because the regfile writes on the falling edge. Always 0 when FWD_EN=1.
//  - MDU FSM, mdu_cnt in [0..MDU_LAT-1], registered:
//    - IDLE (cnt=0, !MulDivE): no hold.
//    - BUSY (MulDivE & cnt<MDU_LAT-1): mduHold=1, cnt<=cnt+1.
//    - DONE (MulDivE & cnt==MDU_LAT-1): mduHold=0, MdDoneE=1, cnt<=0.
//    - MDU_LAT=1: every MulDivE cycle is DONE. Back-to-back MUL/DIV restarts from cnt=0.
//    - If MulDivE drops while cnt!=0 (only by reset), cnt<=0.
//  - Priority, highest first:
//    1. mduHold: StallF=StallD=StallE=1, FlushM=1. Load-use and branch are ignored;
//       while E is frozen, PCSrcE/ResultSrcE0 are 0 (E holds the MUL/DIV).
//    2. PCSrcE: FlushD=FlushE=1, no stall. The taken branch suppresses lwStall/rawStall
//       (the D instruction is being squashed).
//    3. lwStall|rawStall: StallF=StallD=1, FlushE=1.
//  - StallE and FlushM are 1 only under mduHold.
//  - StallCnt: +1 on each cycle with StallF=1; holds at 2^CNT_W-1.
//  - All stall/flush/forward outputs are combinational from the inputs and mdu_cnt,
//    with zero-cycle latency. MdDoneE is combinational from mdu_cnt.
// TESTING
//  1. FWD: RdM=5,RegWriteM=1, RdW=5,RegWriteW=1, Rs1E=5 -> ForwardAE=10.
//     Same with RdM=0 -> ForwardAE=01.
//  2. Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle.
//     Add PCSrcE=1 -> only FlushD=FlushE=1.
//  3. MDU_LAT=4, MulDivE held high -> StallF/D/E=FlushM=1 for 3 cycles, then MdDoneE=1
//     for 1 cycle. StallCnt +3.
//  4. rst=1 asserted at MDU cycle 2 -> next cycle all outputs 0 and cnt=0.
//     Reapplying MulDivE gives a full 3-cycle hold.
//  5. FWD_EN=0: RegWriteM=1, RdM=3, Rs1D=3 -> StallF=StallD=FlushE=1, ForwardAE=00.
//     Same match in W only -> no stall.
//  6. CNT_W=4: hold stall for 20 cycles -> StallCnt=15, stays 15.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use and RAW interlocks,
// branch flush, multi-cycle MUL/DIV hold and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned FWD_EN  = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [REG_AW-1:0] i_rs1_d,
   input  logic [REG_AW-1:0] i_rs2_d,
   input  logic [REG_AW-1:0] i_rs1_e,
   input  logic [REG_AW-1:0] i_rs2_e,
   input  logic [REG_AW-1:0] i_rd_e,
   input  logic [REG_AW-1:0] i_rd_m,
   input  logic [REG_AW-1:0] i_rd_w,
   input  logic              i_reg_write_e,
   input  logic              i_reg_write_m,
   input  logic              i_reg_write_w,
   input  logic              i_result_src_e0,
   input  logic              i_pc_src_e,
   input  logic              i_mul_div_e,
   output logic              o_stall_f,
   output logic              o_stall_d,
   output logic              o_stall_e,
   output logic              o_flush_d,
   output logic              o_flush_e,
   output logic              o_flush_m,
   output logic [1:0]        o_forward_ae,
   output logic [1:0]        o_forward_be,
   output logic              o_md_done_e,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam int unsigned   CW       = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
   localparam logic [CW-1:0] MDU_LAST = CW'(MDU_LAT - 1);
   localparam bit            FWD      = (FWD_EN != 0);

   logic [CW-1:0]    r_mdu_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_mdu_last;
   logic w_mdu_hold;
   logic w_rde_hit_d;
   logic w_rdm_hit_d;
   logic w_lw_stall;
   logic w_raw_stall;

   assign w_mdu_last  = (r_mdu_cnt == MDU_LAST);
   assign w_mdu_hold  = i_mul_div_e & ~w_mdu_last;
   assign w_rde_hit_d = (i_rd_e != '0) & ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));
   assign w_rdm_hit_d = (i_rd_m != '0) & ((i_rd_m == i_rs1_d) | (i_rd_m == i_rs2_d));
   assign w_lw_stall  = i_result_src_e0 & w_rde_hit_d;
   // W never needs an interlock: the regfile writes on the falling edge.
   assign w_raw_stall = ~FWD & ((i_reg_write_e & w_rde_hit_d) | (i_reg_write_m & w_rdm_hit_d));

   always_comb begin
      o_stall_f    = 1'b0;
      o_stall_d    = 1'b0;
      o_stall_e    = 1'b0;
      o_flush_d    = 1'b0;
      o_flush_e    = 1'b0;
      o_flush_m    = 1'b0;
      o_forward_ae = 2'b00;
      o_forward_be = 2'b00;
      o_md_done_e  = 1'b0;
      if (!i_rst) begin
         if (FWD) begin
            if (i_reg_write_m && i_rd_m != '0 && i_rd_m == i_rs1_e) o_forward_ae = 2'b10;
            else if (i_reg_write_w && i_rd_w != '0 && i_rd_w == i_rs1_e) o_forward_ae = 2'b01;
            if (i_reg_write_m && i_rd_m != '0 && i_rd_m == i_rs2_e) o_forward_be = 2'b10;
            else if (i_reg_write_w && i_rd_w != '0 && i_rd_w == i_rs2_e) o_forward_be = 2'b01;
         end
         o_md_done_e = i_mul_div_e & w_mdu_last;
         if (w_mdu_hold) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_flush_m = 1'b1;
         end else if (i_pc_src_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
         end else if (w_lw_stall || w_raw_stall) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
         end
      end
   end

   assign o_stall_cnt = i_rst ? '0 : r_stall_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mdu_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (i_mul_div_e && !w_mdu_last) r_mdu_cnt <= r_mdu_cnt + CW'(1);
         else                            r_mdu_cnt <= '0;
         if (o_stall_f && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two configurations checked every cycle against a behavioural
// model, plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl_mc;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic       rwe, rwm, rww, lde, pcs, mul;

   logic        sf_a, sd_a, se_a, fld_a, fle_a, flm_a, dn_a;
   logic        sf_b, sd_b, se_b, fld_b, fle_b, flm_b, dn_b;
   logic [1:0]  fa_a, fb_a, fa_b, fb_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   logic [10:0] got_a, got_b;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state: length of the current unbroken MulDivE run, and stall counts
   int run_a = 0, run_b = 0;
   int mcnt_a = 0, mcnt_b = 0;

   always #5 clk = ~clk;

   hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(LAT_A), .FWD_EN(1), .CNT_W(16)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_rs1_d(rs1d), .i_rs2_d(rs2d), .i_rs1_e(rs1e),
      .i_rs2_e(rs2e), .i_rd_e(rde), .i_rd_m(rdm), .i_rd_w(rdw), .i_reg_write_e(rwe),
      .i_reg_write_m(rwm), .i_reg_write_w(rww), .i_result_src_e0(lde), .i_pc_src_e(pcs),
      .i_mul_div_e(mul), .o_stall_f(sf_a), .o_stall_d(sd_a), .o_stall_e(se_a),
      .o_flush_d(fld_a), .o_flush_e(fle_a), .o_flush_m(flm_a), .o_forward_ae(fa_a),
      .o_forward_be(fb_a), .o_md_done_e(dn_a), .o_stall_cnt(cnt_a)
   );

   hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(LAT_B), .FWD_EN(0), .CNT_W(4)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_rs1_d(rs1d), .i_rs2_d(rs2d), .i_rs1_e(rs1e),
      .i_rs2_e(rs2e), .i_rd_e(rde), .i_rd_m(rdm), .i_rd_w(rdw), .i_reg_write_e(rwe),
      .i_reg_write_m(rwm), .i_reg_write_w(rww), .i_result_src_e0(lde), .i_pc_src_e(pcs),
      .i_mul_div_e(mul), .o_stall_f(sf_b), .o_stall_d(sd_b), .o_stall_e(se_b),
      .o_flush_d(fld_b), .o_flush_e(fle_b), .o_flush_m(flm_b), .o_forward_ae(fa_b),
      .o_forward_be(fb_b), .o_md_done_e(dn_b), .o_stall_cnt(cnt_b)
   );

   assign got_a = {sf_a, sd_a, se_a, fld_a, fle_a, flm_a, fa_a, fb_a, dn_a};
   assign got_b = {sf_b, sd_b, se_b, fld_b, fle_b, flm_b, fa_b, fb_b, dn_b};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rwm && rdm != 0 && rdm == rs) return 2'b10;
      if (rww && rdw != 0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Expected {sf,sd,se,fld,fle,flm,fa,fb,done} from the current inputs and MulDivE run length
   function automatic logic [10:0] m_exp(input bit fe, input int lat, input int run);
      logic hold, done, lw, raw, sf, sd, se, fld, fle, flm;
      logic [1:0] fa, fb;
      if (rst) return '0;
      hold = mul && (run % lat) != lat - 1;
      done = mul && (run % lat) == lat - 1;
      lw   = lde && rde != 0 && (rde == rs1d || rde == rs2d);
      raw  = !fe && ((rwe && rde != 0 && (rde == rs1d || rde == rs2d)) ||
                     (rwm && rdm != 0 && (rdm == rs1d || rdm == rs2d)));
      fa   = fe ? m_fwd(rs1e) : 2'b00;
      fb   = fe ? m_fwd(rs2e) : 2'b00;
      {sf, sd, se, fld, fle, flm} = '0;
      if (hold)           {sf, sd, se, flm} = 4'b1111;
      else if (pcs)       {fld, fle} = 2'b11;
      else if (lw || raw) {sf, sd, fle} = 3'b111;
      return {sf, sd, se, fld, fle, flm, fa, fb, done};
   endfunction

   always @(posedge clk) begin
      logic [10:0] ea, eb;
      ea = m_exp(1'b1, LAT_A, run_a);
      eb = m_exp(1'b0, LAT_B, run_b);
      if (rst) begin
         mcnt_a = 0;
         mcnt_b = 0;
      end else begin
         if (ea[10] && mcnt_a < 65535) mcnt_a++;
         if (eb[10] && mcnt_b < 15) mcnt_b++;
      end
      run_a = (rst || !mul) ? 0 : run_a + 1;
      run_b = (rst || !mul) ? 0 : run_b + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_a", 32'(got_a), 32'(m_exp(1'b1, LAT_A, run_a)));
         check("model_b", 32'(got_b), 32'(m_exp(1'b0, LAT_B, run_b)));
         check("cnt_a", 32'(cnt_a), rst ? 32'd0 : 32'(mcnt_a));
         check("cnt_b", 32'(cnt_b), rst ? 32'd0 : 32'(mcnt_b));
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr();
      {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
      {rwe, rwm, rww, lde, pcs, mul} = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int holds;
      rst = 1'b1;
      clr();
      nxt();
      chk_en = 1'b1;
      mul = 1'b1; lde = 1'b1; rde = 5'd7; rs1d = 5'd7; pcs = 1'b1;
      smp();
      check("rst_stall_f", 32'(sf_a), 0);
      check("rst_flush_d", 32'(fld_a), 0);
      check("rst_cnt", 32'(cnt_a), 0);
      check("rst_done_b", 32'(dn_b), 0);
      nxt(); rst = 1'b0; clr();

      // Forwarding: M beats W, RdM=0 falls through to W
      rdm = 5'd5; rwm = 1'b1; rdw = 5'd5; rww = 1'b1; rs1e = 5'd5;
      smp();
      check("fwd_m", 32'(fa_a), 32'b10);
      check("fwd_off_b", 32'(fa_b), 0);
      nxt(); rdm = 5'd0;
      smp();
      check("fwd_w", 32'(fa_a), 32'b01);

      // Load-use, then branch overriding it
      nxt(); clr(); lde = 1'b1; rde = 5'd7; rs2d = 5'd7;
      smp();
      check("lw_stall", 32'({sf_a, sd_a, fle_a, fld_a}), 32'b1110);
      nxt(); pcs = 1'b1;
      smp();
      check("lw_branch", 32'({sf_a, sd_a, fle_a, fld_a}), 32'b0011);

      // MDU hold: three frozen cycles then done
      nxt(); clr(); rst = 1'b1;
      nxt(); rst = 1'b0; mul = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         check("mdu_hold", 32'({sf_a, sd_a, se_a, flm_a, dn_a}), 32'b11110);
         nxt();
      end
      smp();
      check("mdu_done", 32'({sf_a, sd_a, se_a, flm_a, dn_a}), 32'b00001);
      check("mdu_done_lat1", 32'(dn_b), 1);
      nxt(); mul = 1'b0;
      smp();
      check("mdu_cnt3", 32'(cnt_a), 3);

      // Reset mid-op, then a full hold again
      nxt(); mul = 1'b1;
      smp(); nxt();
      smp(); nxt(); rst = 1'b1;
      smp();
      check("mdu_rst_out", 32'(got_a), 0);
      check("mdu_rst_cnt", 32'(cnt_a), 0);
      nxt(); rst = 1'b0;
      holds = 0;
      for (int i = 0; i < 10; i++) begin
         smp();
         if (dn_a) break;
         if (se_a) holds++;
         nxt();
      end
      check("mdu_rehold", 32'(holds), 3);
      check("mdu_redone", 32'(dn_a), 1);
      nxt(); mul = 1'b0;

      // No forwarding: M match interlocks, W match does not
      clr(); rst = 1'b1;
      nxt(); rst = 1'b0; rwm = 1'b1; rdm = 5'd3; rs1d = 5'd3; rs1e = 5'd3;
      smp();
      check("raw_m_b", 32'({sf_b, sd_b, fle_b, fa_b}), 32'b11100);
      check("raw_m_a", 32'({sf_a, fa_a}), 32'b010);
      nxt(); rwm = 1'b0; rww = 1'b1; rdw = 5'd3;
      smp();
      check("raw_w_b", 32'(sf_b), 0);
      check("raw_w_a", 32'(fa_a), 32'b01);

      // Counter saturation at 4 bits
      nxt(); clr(); rst = 1'b1;
      nxt(); rst = 1'b0; lde = 1'b1; rde = 5'd7; rs1d = 5'd7;
      repeat (20) nxt();
      smp();
      check("sat_b", 32'(cnt_b), 15);
      check("sat_a", 32'(cnt_a), 20);
      nxt();
      smp();
      check("sat_b_hold", 32'(cnt_b), 15);
      check("sat_a_inc", 32'(cnt_a), 21);

      // Random traffic against the model
      nxt(); clr(); rst = 1'b1;
      nxt(); rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
         rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
         rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
         rdw  = 5'($urandom_range(0, 3));
         rwe  = 1'($urandom_range(0, 1)); rwm = 1'($urandom_range(0, 1));
         rww  = 1'($urandom_range(0, 1)); lde = 1'($urandom_range(0, 1));
         pcs  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) >= 8) mul = ~mul;
         nxt();
      end
      smp();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
